// File: rtl/mc_datapath_if.sv
// mc_datapath_if
//   Bundles the control word from the main control FSM, the unified memory
//   bus and the status flags returned to the controller.
//   master : controller/memory side (drives control + readdata)
//   slave  : datapath side (drives adr, writedata, op, zero)
interface mc_datapath_if;
  // control word
  logic        memtoreg;
  logic        alusrc_a;
  logic [1:0]  alusrc_b;
  logic        regdst;
  logic        regwrite;
  logic        pcen;
  logic        iord;
  logic        irwrite;
  logic [1:0]  pcsrc;
  logic [1:0]  aluop;
  // memory bus
  logic [31:0] readdata;
  logic [31:0] adr;
  logic [31:0] writedata;
  // status to controller
  logic [5:0]  op;
  logic        zero;

  modport master (
    output memtoreg, alusrc_a, alusrc_b, regdst, regwrite, pcen,
           iord, irwrite, pcsrc, aluop, readdata,
    input  adr, writedata, op, zero
  );

  modport slave (
    input  memtoreg, alusrc_a, alusrc_b, regdst, regwrite, pcen,
           iord, irwrite, pcsrc, aluop, readdata,
    output adr, writedata, op, zero
  );
endinterface

// File: rtl/mc_datapath.sv
// mc_datapath
//   Multicycle MIPS datapath: PC, IR, memory data register, 32-entry
//   register file, A/B operand latches, ALU with function decode and ALUOut.
//   Sequenced one step per clock by an external control FSM.
// Ports:
//   clk   - clock, all state updates on the rising edge
//   reset - asynchronous, active-low reset
//   bus   - mc_datapath_if.slave: control word in, memory readdata in,
//           adr/writedata to memory, op/zero back to the controller
module mc_datapath #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NREGS    = 32
) (
  input  logic         clk,
  input  logic         reset,
  mc_datapath_if.slave bus
);

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_fn_t;

  // architectural / pipeline-step registers
  logic [31:0] pc_reg;
  logic [31:0] ir_reg;
  logic [31:0] data_reg;
  logic [31:0] a_reg;
  logic [31:0] b_reg;
  logic [31:0] aluout_reg;
  logic [31:0] rf_reg [NREGS];

  logic [4:0]       ra1, ra2, wa;
  logic [31:0]      rd1, rd2, wd;
  logic [31:0]      sign_imm;
  logic [31:0]      src_a, src_b;
  logic [31:0]      alu_result;
  logic [31:0]      pc_jump, pc_next;
  logic [NREGS-1:0] rf_we;
  alu_fn_t          alu_fn;

  // ---------------------------------------------------------------- decode
  assign ra1      = ir_reg[25:21];
  assign ra2      = ir_reg[20:16];
  assign wa       = bus.regdst ? ir_reg[15:11] : ir_reg[20:16];
  assign wd       = bus.memtoreg ? data_reg : aluout_reg;
  assign sign_imm = {{16{ir_reg[15]}}, ir_reg[15:0]};
  assign pc_jump  = {pc_reg[31:28], ir_reg[25:0], 2'b00};

  // ---------------------------------------------------------- register file
  // One write strobe per entry; entry 0 never gets a strobe so $0 stays 0.
  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_rf_we
      if (gi == 0) begin : g_zero
        assign rf_we[gi] = 1'b0;
      end else begin : g_reg
        assign rf_we[gi] = bus.regwrite && (wa == 5'(gi));
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        rf_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (rf_we[i]) begin
          rf_reg[i] <= wd;
        end
      end
    end
  end

  // Combinational read of pre-edge contents: a same-edge write is not
  // forwarded into A/B.
  assign rd1 = (ra1 == 5'd0) ? 32'd0 : rf_reg[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : rf_reg[ra2];

  // ------------------------------------------------------------ ALU control
  always_comb begin
    alu_fn = ALU_ADD;
    case (bus.aluop)
      2'b01: alu_fn = ALU_SUB;
      2'b10: begin
        case (ir_reg[5:0])
          6'b100010: alu_fn = ALU_SUB;
          6'b100100: alu_fn = ALU_AND;
          6'b100101: alu_fn = ALU_OR;
          6'b101010: alu_fn = ALU_SLT;
          default:   alu_fn = ALU_ADD;  // 100000 and unknown functs
        endcase
      end
      default: alu_fn = ALU_ADD;        // 00 and 11
    endcase
  end

  // -------------------------------------------------------------------- ALU
  assign src_a = bus.alusrc_a ? a_reg : pc_reg;

  always_comb begin
    src_b = b_reg;
    case (bus.alusrc_b)
      2'b00:   src_b = b_reg;
      2'b01:   src_b = 32'd4;
      2'b10:   src_b = sign_imm;
      default: src_b = {sign_imm[29:0], 2'b00};
    endcase
  end

  always_comb begin
    alu_result = src_a + src_b;
    case (alu_fn)
      ALU_SUB: alu_result = src_a - src_b;
      ALU_AND: alu_result = src_a & src_b;
      ALU_OR:  alu_result = src_a | src_b;
      ALU_SLT: alu_result = {31'd0, ($signed(src_a) < $signed(src_b))};
      default: alu_result = src_a + src_b;
    endcase
  end

  // ---------------------------------------------------------------- next PC
  always_comb begin
    pc_next = alu_result;
    case (bus.pcsrc)
      2'b01:   pc_next = aluout_reg;
      2'b10:   pc_next = pc_jump;
      default: pc_next = alu_result;
    endcase
  end

  // -------------------------------------------------------- state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_reg     <= RESET_PC;
      ir_reg     <= '0;
      data_reg   <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      aluout_reg <= '0;
    end else begin
      if (bus.pcen) begin
        pc_reg <= pc_next;
      end
      if (bus.irwrite) begin
        ir_reg <= bus.readdata;
      end
      data_reg   <= bus.readdata;
      a_reg      <= rd1;
      b_reg      <= rd2;
      aluout_reg <= alu_result;
    end
  end

  // ---------------------------------------------------------------- outputs
  assign bus.adr       = bus.iord ? aluout_reg : pc_reg;
  assign bus.writedata = b_reg;
  assign bus.op        = ir_reg[31:26];
  assign bus.zero      = (alu_result == 32'd0);

endmodule

// File: doc/mc_datapath.md
Name: mc_datapath

Overview:
- Multicycle MIPS datapath driven cycle by cycle by the main control FSM.
- Holds PC, IR, memory data register, register file, A/B operand latches, ALU, ALU-function decode and ALUOut.
- Sends op and zero back to the controller.
- Drives address and write data to the unified instruction/data memory and consumes its read data.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NREGS, 32, register-file depth; fixed at 32 for MIPS, index width 5.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- memtoreg  in  1  regfile write data: 0=ALUOut, 1=Data.
- alusrc_a  in  1  ALU A operand: 0=PC, 1=A.
- alusrc_b  in  2  ALU B operand: 00=B, 01=32'd4, 10=SignImm, 11=SignImm<<2.
- regdst  in  1  write register: 0=IR[20:16], 1=IR[15:11].
- regwrite  in  1  regfile write enable.
- pcen  in  1  PC load enable; branch&zero is already folded in upstream.
- iord  in  1  memory address: 0=PC, 1=ALUOut.
- irwrite  in  1  IR load enable.
- pcsrc  in  2  next PC: 00=ALUResult, 01=ALUOut, 10={PC[31:28],IR[25:0],2'b00}, 11=ALUResult.
- aluop  in  2  00=add, 01=sub, 10=use funct, 11=add.
- readdata  in  32  memory read data.
- adr  out  32  memory address.
- writedata  out  32  memory write data; always equals B.
- op  out  6  IR[31:26].
- zero  out  1  ALUResult==0, combinational.

Behaviour:
- Reset (reset=0, asynchronous):
  - PC=RESET_PC.
  - IR, Data, A, B, ALUOut and all 32 registers = 0.
  - Outputs follow: adr=RESET_PC, op=0, writedata=0.
  - Reset asserted mid-instruction aborts it immediately; no partial register or PC write survives.
- Per rising edge with reset=1:
  - IR <= readdata if irwrite.
  - Data <= readdata, unconditionally.
  - A <= rf[IR[25:21]], unconditionally.
  - B <= rf[IR[20:16]], unconditionally.
  - ALUOut <= ALUResult, unconditionally.
  - PC <= next-PC mux if pcen.
  - rf[wa] <= wd if regwrite and wa!=0.
- Register $0 reads 0 always; writes to it are dropped.
- Regfile read is combinational and returns the pre-edge value. A write and an A/B capture of the same index on the same edge gives A/B the OLD value.
- Sign extend: SignImm = {{16{IR[15]}}, IR[15:0]}.
- ALU control:
  - aluop 00 or 11: add.
  - aluop 01: sub.
  - aluop 10, funct IR[5:0]:
    - 100000 add.
    - 100010 sub.
    - 100100 and.
    - 100101 or.
    - 101010 slt (signed; result 32'd1 or 32'd0).
    - Any other funct: add.
- Arithmetic is 32-bit and wraps modulo 2^32; no overflow flag or trap.
- adr = iord ? ALUOut : PC, combinational.
- PC may be loaded with any value. Misaligned PC is not checked; PC+4 wraps at 32'hFFFF_FFFC -> 0.
- Latency:
  - Control inputs take effect on the next edge.
  - zero, adr and op respond combinationally within the same cycle.

Test Plan:
- Reset: hold reset=0 with random control inputs -> PC=0, adr=0, op=0; rf[1..31] read 0 once released.
- Fetch: readdata=32'h2008_0005; alusrc_a=0, alusrc_b=01, aluop=00, pcsrc=00, pcen=1, irwrite=1 for one edge -> PC=4, IR=32'h2008_0005, op=6'b001000.
- ADDI 3-step (decode; alusrc_a=1, alusrc_b=10; regwrite=1, regdst=0, memtoreg=0) -> rf[8]=5. Repeat with imm 16'hFFFF -> rf[8]=32'hFFFF_FFFF (sign extension).
- R-type slt: rf[8]=-1, rf[9]=1, IR=32'h0109_502A, aluop=10 -> rf[10]=1; swap operands -> rf[10]=0. Write to rd=0 -> rf[0] still 0.
- LW then SW:
  - lw IR=32'h8C0B_0010, iord=1 -> adr=32'h10; readdata=32'hCAFE_F00D, memtoreg=1 -> rf[11]=32'hCAFE_F00D.
  - sw of rf[11] -> writedata=32'hCAFE_F00D with adr=ALUOut.
- BEQ and jump:
  - beq taken at PC=8, imm=3: decode computes 8+4+12 -> ALUOut=24; branch cycle gives zero=1; pcen=1, pcsrc=01 -> PC=24.
  - j IR=32'h0800_0040 at PC=32'h1000_0004 -> PC=32'h1000_0100.
  - Reset pulse in any cycle -> PC=0 asynchronously, before the next edge.
